c2h_byte_packer: RTL and testbench

//  Packs the 8-bit ping-pong RAM read stream (byte + valid) into DATA_W-wide AXI-Stream C2H beats for the PCIe DMA.

---
 rtl/c2h_byte_packer.sv | 148 ++++++++++++++
 tb/tb_c2h_byte_packer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/c2h_byte_packer.sv
// Packs an 8-bit byte stream into DATA_W-wide AXI-Stream C2H beats through a first-word-fall-through beat FIFO.
// Optional statistics counters are enabled with the C2H_PACKER_STAT_EN macro.
module c2h_byte_packer #(
  parameter int DATA_W       = 64,
  parameter int PKT_BYTES    = 4096,
  parameter int FIFO_DEPTH   = 16,
  parameter int AFULL_MARGIN = 4
) (
  input  logic              usr_clk,
  input  logic              usr_rst,
  input  logic              run,
  input  logic [7:0]        data_in,
  input  logic              data_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              overflow
`ifdef C2H_PACKER_STAT_EN
  ,
  output logic [31:0]       stat_beats,
  output logic [15:0]       stat_drops
`endif
);

  localparam int BPB = DATA_W / 8;
  localparam int LW  = (BPB > 1) ? $clog2(BPB) : 1;
  localparam int BW  = $clog2(PKT_BYTES);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_FLUSH} state_t;

  state_t            r_state, w_state_next;
  logic [LW-1:0]     r_lane, w_lane_next;
  logic [BW-1:0]     r_byte;
  logic [DATA_W-1:0] r_beat, w_beat;
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [CW-1:0]     r_count;
  logic              r_overflow;
  logic [DATA_W-1:0] r_mem_data [FIFO_DEPTH];
  logic [BPB-1:0]    r_mem_keep [FIFO_DEPTH];
  logic              r_mem_last [FIFO_DEPTH];

  logic           w_accept, w_lane_last, w_byte_last, w_full_push, w_flush_push;
  logic           w_pop, w_room, w_push_ok, w_drop, w_push_last;
  logic [BPB-1:0] w_flush_keep, w_push_keep;

  assign w_accept    = data_valid && (r_state == S_FILL || r_state == S_DRAIN);
  assign w_lane_last = (r_lane == LW'(BPB - 1));
  assign w_byte_last = (r_byte == BW'(PKT_BYTES - 1));
  assign w_pop       = (r_count != '0) && m_axis_tready;
  // A full FIFO still takes a push when the head is leaving in the same cycle.
  assign w_room      = (r_count != CW'(FIFO_DEPTH)) || w_pop;

  genvar gi;
  generate
    for (gi = 0; gi < BPB; gi++) begin : g_lane
      assign w_beat[gi*8 +: 8] = (w_accept && r_lane == LW'(gi)) ? data_in : r_beat[gi*8 +: 8];
      assign w_flush_keep[gi]  = (LW'(gi) < r_lane);
    end
  endgenerate

  assign w_full_push  = w_accept && w_lane_last;
  assign w_flush_push = (r_state == S_FLUSH) && w_room;
  assign w_push_ok    = (w_full_push && w_room) || w_flush_push;
  assign w_drop       = w_full_push && !w_room;
  assign w_push_keep  = w_full_push ? {BPB{1'b1}} : w_flush_keep;
  assign w_push_last  = w_full_push ? w_byte_last : 1'b1;
  assign w_lane_next  = w_accept ? (w_lane_last ? '0 : r_lane + LW'(1)) : r_lane;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (run) w_state_next = S_FILL;
      S_FILL:  if (!run) w_state_next = S_DRAIN;
      S_DRAIN: w_state_next = (w_lane_next != '0) ? S_FLUSH : S_IDLE;
      S_FLUSH: if (w_room) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge usr_clk) begin
    if (usr_rst) begin
      r_state    <= S_IDLE;
      r_lane     <= '0;
      r_byte     <= '0;
      r_beat     <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_flush_push) begin
        r_lane <= '0;
        r_byte <= '0;
        r_beat <= '0;
      end else if (w_accept) begin
        // Counters advance even when the beat is dropped so framing survives overflow.
        r_lane <= w_lane_next;
        r_byte <= w_byte_last ? '0 : r_byte + BW'(1);
        r_beat <= w_lane_last ? '0 : w_beat;
      end
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop)     r_rptr <= r_rptr + AW'(1);
      r_count    <= r_count + CW'(w_push_ok) - CW'(w_pop);
      r_overflow <= r_overflow | w_drop;
    end
  end

  always_ff @(posedge usr_clk) begin
    if (w_push_ok) begin
      r_mem_data[r_wptr] <= w_beat;
      r_mem_keep[r_wptr] <= w_push_keep;
      r_mem_last[r_wptr] <= w_push_last;
    end
  end

  // Outputs are gated so they read as zero whenever no beat is held.
  assign m_axis_tvalid = (r_count != '0);
  assign m_axis_tdata  = m_axis_tvalid ? r_mem_data[r_rptr] : '0;
  assign m_axis_tkeep  = m_axis_tvalid ? r_mem_keep[r_rptr] : '0;
  assign m_axis_tlast  = m_axis_tvalid && r_mem_last[r_rptr];
  assign overflow      = r_overflow;
  assign in_ready      = (r_state == S_FILL) && run && (r_count <= CW'(FIFO_DEPTH - AFULL_MARGIN));

`ifdef C2H_PACKER_STAT_EN
  logic [31:0] r_stat_beats;
  logic [15:0] r_stat_drops;

  always_ff @(posedge usr_clk) begin
    if (usr_rst) begin
      r_stat_beats <= '0;
      r_stat_drops <= '0;
    end else begin
      if (w_pop) r_stat_beats <= r_stat_beats + 32'd1;
      if (w_drop && r_stat_drops != 16'hFFFF) r_stat_drops <= r_stat_drops + 16'd1;
    end
  end

  assign stat_beats = r_stat_beats;
  assign stat_drops = r_stat_drops;
`endif

endmodule

// File: tb/tb_c2h_byte_packer.sv
// Directed bench for c2h_byte_packer: beat packing, packet framing, flush, overflow and reset.
// Statistics checks are compiled in when C2H_PACKER_STAT_EN is defined.
module tb_c2h_byte_packer;

  localparam int PKT = 4096;

  logic        usr_clk = 1'b0;
  logic        usr_rst;
  logic        run;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        in_ready;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        overflow;
`ifdef C2H_PACKER_STAT_EN
  logic [31:0] stat_beats;
  logic [15:0] stat_drops;
`endif

  int n_checks = 0;
  int n_err    = 0;
  logic [72:0] q[$];
  logic [72:0] ent;

  c2h_byte_packer dut (
    .usr_clk       (usr_clk),
    .usr_rst       (usr_rst),
    .run           (run),
    .data_in       (data_in),
    .data_valid    (data_valid),
    .in_ready      (in_ready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .overflow      (overflow)
`ifdef C2H_PACKER_STAT_EN
    ,
    .stat_beats    (stat_beats),
    .stat_drops    (stat_drops)
`endif
  );

  always #5 usr_clk = ~usr_clk;

  // Every accepted beat is captured as {tlast, tkeep, tdata}.
  always @(posedge usr_clk)
    if (!usr_rst && m_axis_tvalid && m_axis_tready)
      q.push_back({m_axis_tlast, m_axis_tkeep, m_axis_tdata});

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge usr_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    data_in    = b;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
  endtask

  // Expected beat k of a stream whose byte i carries value i mod 256.
  function automatic logic [63:0] ramp_beat(input int k);
    logic [63:0] d;
    int v;
    for (int j = 0; j < 8; j++) begin
      v = 8 * k + j;
      d[j*8 +: 8] = v[7:0];
    end
    return d;
  endfunction

  task automatic send_packet(input string tag);
    int bad_data;
    int bad_last;
    q.delete();
    for (int i = 0; i < PKT; i++) send_byte(i[7:0]);
    repeat (4) step();
    chk({tag, "_beats"}, 64'(q.size()), 64'd512);
    bad_data = 0;
    bad_last = 0;
    for (int k = 0; k < q.size(); k++) begin
      ent = q[k];
      if (ent[63:0] !== ramp_beat(k) || ent[71:64] !== 8'hFF) bad_data++;
      if (ent[72] !== (k == 511)) bad_last++;
    end
    chk({tag, "_bad_data"}, 64'(bad_data), 64'd0);
    chk({tag, "_bad_tlast"}, 64'(bad_last), 64'd0);
  endtask

  initial begin
    usr_rst = 1'b1; run = 1'b0; data_in = 8'h00; data_valid = 1'b0; m_axis_tready = 1'b0;
    step(); step();
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tdata", m_axis_tdata, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    usr_rst = 1'b0;

    // Scenario 1: one beat of bytes 01..08
    run = 1'b1; m_axis_tready = 1'b1;
    chk("s1_idle_in_ready", 64'(in_ready), 64'd0);
    step();
    chk("s1_fill_in_ready", 64'(in_ready), 64'd1);
    for (int i = 1; i <= 7; i++) send_byte(8'(i));
    chk("s1_tvalid_before", 64'(m_axis_tvalid), 64'd0);
    send_byte(8'h08);
    chk("s1_tvalid_latency", 64'(m_axis_tvalid), 64'd1);
    chk("s1_tdata", m_axis_tdata, 64'h0807060504030201);
    chk("s1_tkeep", 64'(m_axis_tkeep), 64'hFF);
    chk("s1_tlast", 64'(m_axis_tlast), 64'd0);
    step();
    chk("s1_tvalid_after_pop", 64'(m_axis_tvalid), 64'd0);

    // Scenario 2: a full packet from a fresh reset
    usr_rst = 1'b1; step(); usr_rst = 1'b0;
    step();
    send_packet("s2");
`ifdef C2H_PACKER_STAT_EN
    chk("s6_stat_beats", 64'(stat_beats), 64'd512);
`endif
    q.delete();
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    repeat (3) step();
    chk("s2_next_beats", 64'(q.size()), 64'd1);
    ent = q[0];
    chk("s2_next_tdata", ent[63:0], 64'h0807060504030201);
    chk("s2_next_tlast", 64'(ent[72]), 64'd0);

    // Scenario 3: partial beat flushed after run drops
    q.delete();
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    run = 1'b0;
    step();
    chk("s3_drain_in_ready", 64'(in_ready), 64'd0);
    repeat (6) step();
    chk("s3_beats", 64'(q.size()), 64'd1);
    ent = q[0];
    chk("s3_tdata_low", 64'(ent[23:0]), 64'hCCBBAA);
    chk("s3_tkeep", 64'(ent[71:64]), 64'h07);
    chk("s3_tlast", 64'(ent[72]), 64'd1);
    run = 1'b1;
    chk("s3_idle_in_ready", 64'(in_ready), 64'd0);
    step();
    chk("s3_refill_in_ready", 64'(in_ready), 64'd1);

    // Scenario 4: back-pressure, almost-full and overflow
    usr_rst = 1'b1; step(); usr_rst = 1'b0;
    m_axis_tready = 1'b0;
    step();
    for (int i = 0; i < 96; i++) send_byte(i[7:0]);
    chk("s4_in_ready_12", 64'(in_ready), 64'd1);
    for (int i = 96; i < 104; i++) send_byte(i[7:0]);
    chk("s4_in_ready_13", 64'(in_ready), 64'd0);
    for (int i = 104; i < 128; i++) send_byte(i[7:0]);
    chk("s4_overflow_at_full", 64'(overflow), 64'd0);
    chk("s4_tdata_held", m_axis_tdata, ramp_beat(0));
    for (int i = 128; i < 136; i++) send_byte(i[7:0]);
    chk("s4_overflow", 64'(overflow), 64'd1);
`ifdef C2H_PACKER_STAT_EN
    chk("s6_stat_drops", 64'(stat_drops), 64'd1);
`endif
    q.delete();
    m_axis_tready = 1'b1;
    repeat (20) step();
    chk("s4_retained", 64'(q.size()), 64'd16);
    for (int k = 0; k < q.size(); k++) begin
      ent = q[k];
      chk($sformatf("s4_beat%0d", k), ent[63:0], ramp_beat(k));
    end
    chk("s4_overflow_sticky", 64'(overflow), 64'd1);

    // Scenario 5: reset in the middle of a packet
    m_axis_tready = 1'b0;
    for (int i = 0; i < 100; i++) send_byte(i[7:0]);
    chk("s5_tvalid_before_rst", 64'(m_axis_tvalid), 64'd1);
    usr_rst = 1'b1;
    step();
    chk("s5_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("s5_rst_overflow", 64'(overflow), 64'd0);
    chk("s5_rst_in_ready", 64'(in_ready), 64'd0);
    usr_rst = 1'b0;
    m_axis_tready = 1'b1;
    step();
    send_packet("s5");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
